// File: rtl/nemu_packet_sink.sv
// rtl/nemu_packet_sink.sv - NEMU per-core packet sink with latency statistics
//
// Purpose:
//   Ejection-side receiver for one core. Buffers router packets in a small
//   FIFO, pops them while the core is not stalled, computes per-packet
//   latency (i_timestamp - tx timestamp, mod 2^32) and accumulates
//   statistics for packets that pop inside the measurement window.
//
// Optional feature macro:
//   NEMU_SINK_HIST_EN - adds o_hist, an 8-bin latency histogram.
//
// Ports:
//   i_clk            clock
//   reset_n          asynchronous reset, active-HIGH (name kept from the codebase)
//   i_timestamp      global cycle counter
//   i_pkt_in         packed packet: {dest[DEST_W], source[SRC_W], data[32], valid}
//   i_core_stall     core not consuming; inhibits FIFO pop
//   o_net_full       backpressure to router (occupancy == FIFO_DEPTH)
//   o_pkt_count      packets counted in the measurement window (saturating)
//   o_latency_sum    sum of counted latencies (saturating)
//   o_latency_min    minimum counted latency
//   o_latency_max    maximum counted latency
//   o_misroute_count popped packets whose dest != PORT_NO (saturating)
//   o_overflow_error sticky: valid presented while o_net_full
//   o_measure_done   measurement window finished
//   o_hist           (NEMU_SINK_HIST_EN only) latency histogram bins

module nemu_packet_sink #(
  parameter int PORT_NO        = 0,
  parameter int FIFO_DEPTH     = 8,
  parameter int WARMUP_CYCLES  = 600,
  parameter int MEASURE_CYCLES = 10000,
  parameter int DEST_W         = 4,
  parameter int SRC_W          = 4,
  localparam int PKT_W         = DEST_W + SRC_W + 33
) (
  input  logic             i_clk,
  input  logic             reset_n,
  input  logic [31:0]      i_timestamp,
  input  logic [PKT_W-1:0] i_pkt_in,
  input  logic             i_core_stall,
  output logic             o_net_full,
  output logic [31:0]      o_pkt_count,
  output logic [47:0]      o_latency_sum,
  output logic [31:0]      o_latency_min,
  output logic [31:0]      o_latency_max,
  output logic [15:0]      o_misroute_count,
  output logic             o_overflow_error,
  output logic             o_measure_done
`ifdef NEMU_SINK_HIST_EN
  ,
  output logic [7:0][31:0] o_hist
`endif
);

  localparam int ENTRY_W = PKT_W - 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [DEST_W-1:0] PORT_ID   = DEST_W'(PORT_NO);
  localparam logic [31:0]       WARMUP_TS = 32'(WARMUP_CYCLES);
  localparam logic [31:0]       DONE_TS   = WARMUP_TS + 32'(MEASURE_CYCLES);

  typedef enum logic [1:0] {ST_WARMUP, ST_MEASURE, ST_DONE} state_t;

  state_t r_state, w_state_nxt;

  // Window FSM: only moves forward, so a timestamp going backwards has no effect.
  always_ff @(posedge i_clk or posedge reset_n) begin
    if (reset_n) r_state <= ST_WARMUP;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_measure_done = 1'b0;
    case (r_state)
      ST_WARMUP:  if (i_timestamp >= WARMUP_TS) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (i_timestamp >= DONE_TS)   w_state_nxt = ST_DONE;
      default: begin
        w_state_nxt    = ST_DONE;
        o_measure_done = 1'b1;
      end
    endcase
  end

  // Ejection FIFO. Contents are not reset; clearing pointers/count discards them.
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               w_valid, w_push, w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [DEST_W-1:0]  w_head_dest;
  logic [SRC_W-1:0]   w_head_src;
  logic [31:0]        w_head_data;

  assign w_valid    = i_pkt_in[0];
  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign o_net_full = (r_count == CNT_FULL);
  assign w_push     = w_valid && !o_net_full;
  assign w_pop      = (r_count != '0) && !i_core_stall;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_dest = w_head[ENTRY_W-1 -: DEST_W];
  assign w_head_src  = w_head[31+SRC_W -: SRC_W];
  assign w_head_data = w_head[31:0];

  // Source is carried through the buffer but plays no part in the statistics.
  logic w_unused_src;
  assign w_unused_src = ^w_head_src;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_pkt_in[PKT_W-1:1];
  end

  always_ff @(posedge i_clk or posedge reset_n) begin
    if (reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_valid && o_net_full) r_overflow <= 1'b1;
    end
  end

  assign o_overflow_error = r_overflow;

  // Stage 1: latency, destination check and window state captured at pop time.
  logic        r_s1_valid, r_s1_dest_ok, r_s1_meas;
  logic [31:0] r_s1_lat;

  always_ff @(posedge i_clk or posedge reset_n) begin
    if (reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_dest_ok <= 1'b0;
      r_s1_meas    <= 1'b0;
      r_s1_lat     <= '0;
    end else begin
      r_s1_valid   <= w_pop;
      r_s1_dest_ok <= (w_head_dest == PORT_ID);
      r_s1_meas    <= (r_state == ST_MEASURE);
      r_s1_lat     <= i_timestamp - w_head_data;
    end
  end

  // Stage 2: statistics accumulation.
  logic        w_count_upd, w_mis_upd;
  logic [48:0] w_sum_ext;
  logic [31:0] r_pkt_count, r_lat_min, r_lat_max;
  logic [47:0] r_lat_sum;
  logic [15:0] r_mis_count;

  assign w_count_upd = r_s1_valid && r_s1_dest_ok && r_s1_meas;
  assign w_mis_upd   = r_s1_valid && !r_s1_dest_ok;
  assign w_sum_ext   = {1'b0, r_lat_sum} + {17'b0, r_s1_lat};

  always_ff @(posedge i_clk or posedge reset_n) begin
    if (reset_n) begin
      r_pkt_count <= '0;
      r_lat_sum   <= '0;
      r_lat_min   <= 32'hFFFF_FFFF;
      r_lat_max   <= '0;
      r_mis_count <= '0;
    end else begin
      if (w_count_upd) begin
        if (r_pkt_count != '1) r_pkt_count <= r_pkt_count + 1'b1;
        r_lat_sum <= w_sum_ext[48] ? '1 : w_sum_ext[47:0];
        if (r_s1_lat < r_lat_min) r_lat_min <= r_s1_lat;
        if (r_s1_lat > r_lat_max) r_lat_max <= r_s1_lat;
      end
      if (w_mis_upd && (r_mis_count != '1)) r_mis_count <= r_mis_count + 1'b1;
    end
  end

  assign o_pkt_count      = r_pkt_count;
  assign o_latency_sum    = r_lat_sum;
  assign o_latency_min    = r_lat_min;
  assign o_latency_max    = r_lat_max;
  assign o_misroute_count = r_mis_count;

`ifdef NEMU_SINK_HIST_EN
  // Bin k covers [2^(k+2), 2^(k+3)); bin 0 also takes <8, bin 7 takes >=512.
  logic [2:0]        w_hist_bin;
  logic [7:0][31:0]  r_hist;

  always_comb begin
    w_hist_bin = 3'd0;
    if (|r_s1_lat[31:9])  w_hist_bin = 3'd7;
    else if (r_s1_lat[8]) w_hist_bin = 3'd6;
    else if (r_s1_lat[7]) w_hist_bin = 3'd5;
    else if (r_s1_lat[6]) w_hist_bin = 3'd4;
    else if (r_s1_lat[5]) w_hist_bin = 3'd3;
    else if (r_s1_lat[4]) w_hist_bin = 3'd2;
    else if (r_s1_lat[3]) w_hist_bin = 3'd1;
  end

  always_ff @(posedge i_clk or posedge reset_n) begin
    if (reset_n) begin
      r_hist <= '0;
    end else if (w_count_upd && (r_hist[w_hist_bin] != '1)) begin
      r_hist[w_hist_bin] <= r_hist[w_hist_bin] + 1'b1;
    end
  end

  assign o_hist = r_hist;
`endif

endmodule

// File: tb/tb_nemu_packet_sink.sv
// tb/tb_nemu_packet_sink.sv - self-checking bench for nemu_packet_sink
module tb_nemu_packet_sink;
  localparam int PORT_NO = 0;
  localparam int DEPTH   = 8;
  localparam int WARM    = 600;
  localparam int MEAS    = 10000;

  logic        i_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] i_timestamp = '0;
  logic [40:0] i_pkt_in = '0;
  logic        i_core_stall = 1'b0;
  logic        o_net_full;
  logic [31:0] o_pkt_count, o_latency_min, o_latency_max;
  logic [47:0] o_latency_sum;
  logic [15:0] o_misroute_count;
  logic        o_overflow_error, o_measure_done;
`ifdef NEMU_SINK_HIST_EN
  logic [7:0][31:0] o_hist;
`endif

  nemu_packet_sink #(
    .PORT_NO(PORT_NO), .FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARM), .MEASURE_CYCLES(MEAS)
  ) dut (
    .i_clk(i_clk), .reset_n(reset_n), .i_timestamp(i_timestamp), .i_pkt_in(i_pkt_in),
    .i_core_stall(i_core_stall), .o_net_full(o_net_full), .o_pkt_count(o_pkt_count),
    .o_latency_sum(o_latency_sum), .o_latency_min(o_latency_min), .o_latency_max(o_latency_max),
    .o_misroute_count(o_misroute_count), .o_overflow_error(o_overflow_error),
    .o_measure_done(o_measure_done)
`ifdef NEMU_SINK_HIST_EN
    , .o_hist(o_hist)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: window derived from the highest timestamp seen so far.
  logic [31:0] max_ts = '0;
  longint      e_cnt = 0;
  longint      e_sum = 0;
  logic [31:0] e_min = 32'hFFFF_FFFF;
  logic [31:0] e_max = '0;
  int          e_mis = 0;
  int          e_hist[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic bit in_measure();
    return (max_ts >= WARM) && (max_ts < WARM + MEAS);
  endfunction

  task automatic account(input logic [3:0] dest, input logic [31:0] lat);
    int b;
    if (dest != PORT_NO) e_mis++;
    else if (in_measure()) begin
      e_cnt++;
      e_sum += longint'(lat);
      if (lat < e_min) e_min = lat;
      if (lat > e_max) e_max = lat;
      b = (lat < 8) ? 0 : 7;
      for (int k = 0; k < 7; k++)
        if (lat >= (32'd1 << (k + 2)) && lat < (32'd1 << (k + 3))) b = k;
      e_hist[b]++;
    end
  endtask

  task automatic set_ts(input logic [31:0] t);
    i_timestamp = t;
    if (t > max_ts) max_ts = t;
    tick(2);
  endtask

  task automatic send(input logic [3:0] dest, input logic [31:0] data, input bit acct = 1'b1);
    i_pkt_in = {dest, 4'($urandom), data, 1'b1};
    if (acct) account(dest, i_timestamp - data);
    tick(1);
  endtask

  task automatic idle(input int n);
    i_pkt_in = '0;
    tick(n);
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".count"}, 64'(o_pkt_count), 64'(e_cnt));
    check({tag, ".sum"}, 64'(o_latency_sum), 64'(e_sum));
    check({tag, ".min"}, 64'(o_latency_min), 64'(e_min));
    check({tag, ".max"}, 64'(o_latency_max), 64'(e_max));
    check({tag, ".mis"}, 64'(o_misroute_count), 64'(e_mis));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".count"}, 64'(o_pkt_count), 64'd0);
    check({tag, ".sum"}, 64'(o_latency_sum), 64'd0);
    check({tag, ".min"}, 64'(o_latency_min), 64'hFFFF_FFFF);
    check({tag, ".max"}, 64'(o_latency_max), 64'd0);
    check({tag, ".mis"}, 64'(o_misroute_count), 64'd0);
    check({tag, ".ovf"}, 64'(o_overflow_error), 64'd0);
    check({tag, ".done"}, 64'(o_measure_done), 64'd0);
    check({tag, ".full"}, 64'(o_net_full), 64'd0);
  endtask

  initial begin
    logic [31:0] ts_r;
    longint      cnt_before;
    int          seen_full;
    logic [3:0]  d;

    foreach (e_hist[i]) e_hist[i] = 0;
    tick(3);
    check_reset_vals("reset");
    reset_n = 1'b0;
    tick(1);

    // Warmup: packets popped but never counted.
    set_ts(100);
    for (int i = 0; i < 5; i++) send(4'(PORT_NO), $urandom);
    idle(4);
    check("warmup.count", 64'(o_pkt_count), 64'd0);
    check("warmup.mis", 64'(o_misroute_count), 64'd0);

    // First counted packet, visible three edges after the push edge.
    set_ts(700);
    send(4'(PORT_NO), 690);
    idle(2);
    check("first.count", 64'(o_pkt_count), 64'd1);
    check("first.sum", 64'(o_latency_sum), 64'd10);
    check("first.min", 64'(o_latency_min), 64'd10);
    check("first.max", 64'(o_latency_max), 64'd10);

    send(4'(PORT_NO), 700);
    idle(4);
    check("lat0.min", 64'(o_latency_min), 64'd0);

    send(4'(PORT_NO + 1), 650);
    idle(4);
    check("misroute.mis", 64'(o_misroute_count), 64'd1);
    check("misroute.count", 64'(o_pkt_count), 64'd2);

    // Timestamp moves backwards: window stays open, latency wraps.
    set_ts(32'h10);
    send(4'(PORT_NO), 32'hFFFF_FFF0);
    idle(4);
    check("wrap.max", 64'(o_latency_max), 64'h20);
    check_stats("wrap");

    // Fill under stall, overflow on the ninth, then drain.
    set_ts(800);
    cnt_before = e_cnt;
    i_core_stall = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(4'(PORT_NO), 32'(800 - 20 * i));
    idle(1);
    check("fill.full", 64'(o_net_full), 64'd1);
    check("fill.ovf_pre", 64'(o_overflow_error), 64'd0);
    send(4'(PORT_NO), 799, 1'b0);
    idle(1);
    check("fill.ovf", 64'(o_overflow_error), 64'd1);
    i_core_stall = 1'b0;
    idle(DEPTH + 4);
    check("fill.drained", 64'(o_pkt_count), 64'(cnt_before + DEPTH));
    check("fill.full_after", 64'(o_net_full), 64'd0);
    check_stats("fill");

    // Random traffic at a fixed timestamp, plus histogram corner latencies.
    set_ts($urandom_range(1000, 9000));
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        d = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'(PORT_NO);
        send(d, i_timestamp - $urandom_range(0, 700));
      end else idle(1);
    end
    send(4'(PORT_NO), i_timestamp - 3);
    send(4'(PORT_NO), i_timestamp - 8);
    send(4'(PORT_NO), i_timestamp - 600);
    idle(4);
    check_stats("random");
    check("random.ovf_sticky", 64'(o_overflow_error), 64'd1);
`ifdef NEMU_SINK_HIST_EN
    for (int k = 0; k < 8; k++) check($sformatf("hist[%0d]", k), 64'(o_hist[k]), 64'(e_hist[k]));
`endif

    // Back-to-back at one packet per cycle with a running timestamp.
    cnt_before = e_cnt;
    seen_full = 0;
    ts_r = 9100;
    for (int i = 0; i < 100; i++) begin
      ts_r = ts_r + 1;
      i_timestamp = ts_r;
      max_ts = ts_r;
      i_pkt_in = {4'(PORT_NO), 4'd0, ts_r - 5, 1'b1};
      tick(1);
      if (o_net_full) seen_full++;
    end
    idle(4);
    e_cnt = cnt_before + 100;
    check("b2b.count", 64'(o_pkt_count), 64'(e_cnt));
    check("b2b.never_full", 64'(seen_full), 64'd0);

    // Window closed: done asserted, nothing further counted.
    set_ts(WARM + MEAS);
    tick(2);
    check("done.flag", 64'(o_measure_done), 64'd1);
    for (int i = 0; i < 5; i++) send(4'(PORT_NO), $urandom);
    idle(4);
    check("done.count", 64'(o_pkt_count), 64'(e_cnt));

    // Asynchronous reset mid-stream with buffered misrouted packets.
    i_core_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(4'(PORT_NO + 1), $urandom);
    i_pkt_in = {4'(PORT_NO + 1), 4'd0, 32'd5, 1'b1};
    #2;
    reset_n = 1'b1;
    #1;
    check_reset_vals("midreset");
    i_timestamp = 0;
    i_pkt_in = '0;
    tick(2);
    reset_n = 1'b0;
    i_core_stall = 1'b0;
    idle(6);
    check("midreset.discard_mis", 64'(o_misroute_count), 64'd0);
    check("midreset.discard_cnt", 64'(o_pkt_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
